// File: rtl/lab_pkg.sv
// Shared definitions for the labyrinth path-search blocks.
//   W        : cost width
//   cost_t   : one cost entry
//   INF      : all-ones cost, marks an excluded or unreached cell
//   state_t  : scan controller FSM states
package lab_pkg;

    localparam int W = 19;

    typedef logic [W-1:0] cost_t;

    localparam cost_t INF = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/min4_idx.sv
// Combinational 4-to-1 minimum tree with lane index.
// Two pair stages: lanes (0,1) and (2,3) are reduced first, then the two
// winners. The lower lane wins on equal values at every stage, so the
// reported lane is the lowest lane holding the minimum.
// Ports:
//   data     in  4*W  lane 0 in bits [W-1:0]
//   min_val  out W    smallest of the four values
//   min_lane out 2    lane that holds min_val
module min4_idx
    import lab_pkg::*;
(
    input  logic [4*W-1:0] data,
    output cost_t          min_val,
    output logic [1:0]     min_lane
);

    cost_t pair_val [2];
    logic  pair_sel [2];

    // First stage: one comparator per lane pair.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_pair
            cost_t lo_val;
            cost_t hi_val;
            assign lo_val = data[(2*gi)*W +: W];
            assign hi_val = data[(2*gi+1)*W +: W];
            // Strict less-than: the upper lane only wins when truly smaller.
            assign pair_sel[gi] = (hi_val < lo_val);
            assign pair_val[gi] = pair_sel[gi] ? hi_val : lo_val;
        end
    endgenerate

    // Second stage: upper pair only wins when strictly smaller.
    always_comb begin
        min_val  = pair_val[0];
        min_lane = {1'b0, pair_sel[0]};
        if (pair_val[1] < pair_val[0]) begin
            min_val  = pair_val[1];
            min_lane = {1'b1, pair_sel[1]};
        end
    end

endmodule

// File: rtl/min_scan_ctrl.sv
// Minimum-cost scan controller.
// Sweeps the cost RAM one 4-entry group per cycle, reduces each group with
// min4_idx and keeps a running minimum with its entry index. INF entries
// never win; the lowest index wins among equal minima.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   start     scan request, only honoured in IDLE
//   busy      high from the cycle after start acceptance until done
//   done      one-cycle pulse, results valid from this cycle
//   rd_en     cost RAM read enable
//   rd_addr   cost RAM group address (entry = rd_addr*4 + lane)
//   rd_data   four lanes of cost, one cycle after rd_en
//   min_val   minimum non-INF cost, INF if none
//   min_idx   entry index of min_val, 0 if none
//   found     at least one non-INF entry seen
module min_scan_ctrl
    import lab_pkg::*;
#(
    parameter  int DEPTH = 64,
    localparam int G     = DEPTH / 4,
    localparam int GW    = $clog2(G),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            rd_en,
    output logic [GW-1:0]   rd_addr,
    input  logic [4*W-1:0]  rd_data,
    output logic [W-1:0]    min_val,
    output logic [AW-1:0]   min_idx,
    output logic            found
);

    state_t          state_reg;
    logic            busy_reg;
    logic            done_reg;
    logic            rd_en_reg;
    logic [GW-1:0]   rd_addr_reg;

    // Tracks which group the returning rd_data belongs to.
    logic            rd_valid_reg;
    logic [GW-1:0]   grp_reg;

    cost_t           min_val_reg;
    logic [AW-1:0]   min_idx_reg;
    logic            found_reg;

    cost_t           gval;
    logic [1:0]      glane;
    logic            start_accept;
    logic            take_group;

    min4_idx u_min4 (
        .data     (rd_data),
        .min_val  (gval),
        .min_lane (glane)
    );

    assign start_accept = (state_reg == IDLE) && start;

    // Strict compare keeps the earlier group on a tie across groups.
    assign take_group = rd_valid_reg && (gval != INF) && (gval < min_val_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            rd_en_reg    <= 1'b0;
            rd_addr_reg  <= '0;
            rd_valid_reg <= 1'b0;
            grp_reg      <= '0;
        end else begin
            done_reg     <= 1'b0;
            rd_valid_reg <= rd_en_reg;
            grp_reg      <= rd_addr_reg;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg   <= SCAN;
                        busy_reg    <= 1'b1;
                        rd_en_reg   <= 1'b1;
                        rd_addr_reg <= '0;
                    end
                end
                SCAN: begin
                    if (rd_addr_reg == GW'(G - 1)) begin
                        state_reg   <= DRAIN;
                        rd_en_reg   <= 1'b0;
                        rd_addr_reg <= '0;
                    end else begin
                        rd_addr_reg <= rd_addr_reg + GW'(1);
                    end
                end
                DRAIN: begin
                    // The last group is folded in on this edge.
                    state_reg <= DONE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_val_reg <= INF;
            min_idx_reg <= '0;
            found_reg   <= 1'b0;
        end else if (start_accept) begin
            min_val_reg <= INF;
            min_idx_reg <= '0;
            found_reg   <= 1'b0;
        end else if (take_group) begin
            min_val_reg <= gval;
            min_idx_reg <= {grp_reg, glane};
            found_reg   <= 1'b1;
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign rd_en   = rd_en_reg;
    assign rd_addr = rd_addr_reg;
    assign min_val = min_val_reg;
    assign min_idx = min_idx_reg;
    assign found   = found_reg;

endmodule
